// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction-cache miss handler with prefetch-buffer reuse and AXI refill
//
// Serves an icache miss either from the line prefetcher's buffer (when it holds or is
// fetching the missing line) or from an 8-beat AXI read burst, then hints the
// prefetcher to fetch the next sequential line.
//
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   miss_req_i, miss_line_addr_i  miss request (level) and missing line address
//   refill_valid_o                one-cycle pulse, refill_addr_o/refill_line_o valid
//   refill_addr_o, refill_line_o  returned line address and 8x32-bit line (word k at [32k+31:32k])
//   line_addr_o, need_prefetch_o  current-line hint and prefetch request to the prefetcher
//   pf_ack_o                      consume the prefetch buffer
//   pf_addr_i, pf_ready_i         prefetched line address, buffer full
//   pf_fetching_i, pf_inst_i      prefetcher busy, prefetched line data
//   axi_ar*/axi_r*                AXI read address and read data channels
//   hit_count_o, miss_count_o     refills served by the prefetch buffer / by AXI
module icache_refill #(
   parameter int LINE_ADDR_W = 27,
   parameter bit PF_ENABLE   = 1'b1
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   miss_req_i,
   input  logic [LINE_ADDR_W-1:0] miss_line_addr_i,
   output logic                   refill_valid_o,
   output logic [LINE_ADDR_W-1:0] refill_addr_o,
   output logic [255:0]           refill_line_o,
   output logic [LINE_ADDR_W-1:0] line_addr_o,
   output logic                   need_prefetch_o,
   output logic                   pf_ack_o,
   input  logic [LINE_ADDR_W-1:0] pf_addr_i,
   input  logic                   pf_ready_i,
   input  logic                   pf_fetching_i,
   input  logic [255:0]           pf_inst_i,
   output logic [31:0]            axi_araddr_o,
   output logic                   axi_arvalid_o,
   input  logic                   axi_arready_i,
   input  logic [31:0]            axi_rdata_i,
   input  logic                   axi_rvalid_i,
   input  logic                   axi_rlast_i,
   output logic                   axi_rready_o,
   output logic [31:0]            hit_count_o,
   output logic [31:0]            miss_count_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_PF = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_READ    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [LINE_ADDR_W-1:0] LINE_ONE = {{(LINE_ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]             state;
   logic [LINE_ADDR_W-1:0] cur_line;
   logic [LINE_ADDR_W-1:0] miss_line;
   logic [2:0]             beat_cnt;
   logic [255:0]           line_q;
   logic [31:0]            hit_cnt;
   logic [31:0]            miss_cnt;

   logic pf_en;
   logic addr_match;
   logic hit;
   logic pend;
   logic pf_dropped;
   logic idle_hit;
   logic wait_hit;

   assign pf_en      = PF_ENABLE;
   assign addr_match = (pf_addr_i == miss_line_addr_i);
   assign hit        = pf_en & pf_ready_i & addr_match;
   assign pend       = pf_en & pf_fetching_i & addr_match;
   assign pf_dropped = !pf_fetching_i & !pf_ready_i;
   assign idle_hit   = (state == S_IDLE) & miss_req_i & hit;
   // WAIT_PF is only reachable with the prefetcher enabled, so no pf_en term here.
   assign wait_hit   = (state == S_WAIT_PF) & pf_ready_i & addr_match;

   // pf_ack_o is combinational on inputs; gate it with resetn so every output is
   // forced low while reset is held, even with a matching buffer presented.
   assign pf_ack_o        = resetn & (idle_hit | wait_hit);
   assign axi_arvalid_o   = (state == S_ADDR);
   assign axi_araddr_o    = axi_arvalid_o ? 32'({miss_line_addr_i, 5'b0}) : 32'd0;
   assign axi_rready_o    = (state == S_READ);
   assign refill_valid_o  = (state == S_DONE);
   assign refill_addr_o   = miss_line;
   assign refill_line_o   = line_q;
   assign line_addr_o     = cur_line;
   assign need_prefetch_o = pf_en & (state == S_DONE) & pf_dropped;
   assign hit_count_o     = hit_cnt;
   assign miss_count_o    = miss_cnt;

   // cur_line advances to miss_line+1 on the edge that enters DONE, so the
   // prefetcher sees the next-line hint in the same cycle as need_prefetch_o.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         cur_line  <= '0;
         miss_line <= '0;
         beat_cnt  <= 3'd0;
         line_q    <= '0;
         hit_cnt   <= 32'd0;
         miss_cnt  <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (miss_req_i) begin
                  miss_line <= miss_line_addr_i;
                  if (hit) begin
                     cur_line <= miss_line_addr_i + LINE_ONE;
                     line_q   <= pf_inst_i;
                     hit_cnt  <= hit_cnt + 32'd1;
                     state    <= S_DONE;
                  end else begin
                     cur_line <= miss_line_addr_i;
                     state    <= pend ? S_WAIT_PF : S_ADDR;
                  end
               end
            end
            S_WAIT_PF: begin
               if (wait_hit) begin
                  cur_line <= miss_line + LINE_ONE;
                  line_q   <= pf_inst_i;
                  hit_cnt  <= hit_cnt + 32'd1;
                  state    <= S_DONE;
               end else if (pf_dropped) begin
                  state <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (axi_arready_i) begin
                  beat_cnt <= 3'd0;
                  state    <= S_READ;
               end
            end
            S_READ: begin
               if (axi_rvalid_i) begin
                  line_q[{beat_cnt, 5'd0} +: 32] <= axi_rdata_i;
                  beat_cnt                       <= beat_cnt + 3'd1;
                  // An early rlast is stored but ignored; only the eighth beat ends the burst.
                  if (axi_rlast_i && (beat_cnt == 3'd7)) begin
                     cur_line <= miss_line + LINE_ONE;
                     miss_cnt <= miss_cnt + 32'd1;
                     state    <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - scoreboard testbench for icache_refill
module tb_icache_refill;

   logic         clock = 1'b0;
   logic         resetn = 1'b0;
   logic         resetn0 = 1'b0;
   logic         miss_req = 1'b0;
   logic [26:0]  miss_addr = '0;
   logic [26:0]  pf_addr = '0;
   logic         pf_ready = 1'b0;
   logic         pf_fetching = 1'b0;
   logic [255:0] pf_inst = '0;
   logic         arready = 1'b0;
   logic [31:0]  rdata = '0;
   logic         rvalid = 1'b0;
   logic         rlast = 1'b0;

   logic         refill_valid, need_pf, pf_ack, arvalid, rready;
   logic [26:0]  refill_addr, line_addr;
   logic [255:0] refill_line;
   logic [31:0]  araddr, hit_cnt, miss_cnt;

   logic         z_refill_valid, z_need_pf, z_pf_ack, z_arvalid, z_rready;
   logic [26:0]  z_refill_addr, z_line_addr;
   logic [255:0] z_refill_line;
   logic [31:0]  z_araddr, z_hit_cnt, z_miss_cnt;

   logic         sel0 = 1'b0;
   logic         m_arvalid, m_refill_valid;
   logic [31:0]  m_araddr;
   assign m_arvalid      = sel0 ? z_arvalid : arvalid;
   assign m_araddr       = sel0 ? z_araddr : araddr;
   assign m_refill_valid = sel0 ? z_refill_valid : refill_valid;

   always #5 clock = ~clock;

   icache_refill #(.LINE_ADDR_W(27), .PF_ENABLE(1'b1)) u_dut (
      .clock(clock), .resetn(resetn),
      .miss_req_i(miss_req), .miss_line_addr_i(miss_addr),
      .refill_valid_o(refill_valid), .refill_addr_o(refill_addr), .refill_line_o(refill_line),
      .line_addr_o(line_addr), .need_prefetch_o(need_pf), .pf_ack_o(pf_ack),
      .pf_addr_i(pf_addr), .pf_ready_i(pf_ready), .pf_fetching_i(pf_fetching), .pf_inst_i(pf_inst),
      .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
      .axi_rdata_i(rdata), .axi_rvalid_i(rvalid), .axi_rlast_i(rlast), .axi_rready_o(rready),
      .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
   );

   icache_refill #(.LINE_ADDR_W(27), .PF_ENABLE(1'b0)) u_dut_nopf (
      .clock(clock), .resetn(resetn0),
      .miss_req_i(miss_req), .miss_line_addr_i(miss_addr),
      .refill_valid_o(z_refill_valid), .refill_addr_o(z_refill_addr), .refill_line_o(z_refill_line),
      .line_addr_o(z_line_addr), .need_prefetch_o(z_need_pf), .pf_ack_o(z_pf_ack),
      .pf_addr_i(pf_addr), .pf_ready_i(pf_ready), .pf_fetching_i(pf_fetching), .pf_inst_i(pf_inst),
      .axi_araddr_o(z_araddr), .axi_arvalid_o(z_arvalid), .axi_arready_i(arready),
      .axi_rdata_i(rdata), .axi_rvalid_i(rvalid), .axi_rlast_i(rlast), .axi_rready_o(z_rready),
      .hit_count_o(z_hit_cnt), .miss_count_o(z_miss_cnt)
   );

   typedef struct {
      logic [26:0]  addr;
      logic [255:0] line;
      logic [26:0]  nxt;
      logic         need;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   refills = 0;
   int   pushed = 0;
   int   ack_cnt = 0;
   int   z_ack_cnt = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [26:0] a, input logic [255:0] l, input logic [26:0] n, input logic nd);
      exp_t e;
      e.addr = a; e.line = l; e.nxt = n; e.need = nd;
      sb.push_back(e);
      pushed++;
   endtask

   // Monitor: pops the expected refill whenever the DUT pulses refill_valid_o.
   always @(negedge clock) begin
      exp_t e;
      if (resetn && pf_ack) ack_cnt++;
      if (resetn0 && z_pf_ack) z_ack_cnt++;
      if (resetn && refill_valid) begin
         refills++;
         if (sb.size() == 0) begin
            chk("unexpected_refill", 1'b1, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("refill_addr", refill_addr, e.addr);
            chk("refill_line", refill_line, e.line);
            chk("line_addr_next", line_addr, e.nxt);
            chk("need_prefetch", need_pf, e.need);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ar_phase(input logic [31:0] exp_addr, input int delay);
      int t = 0;
      while (!m_arvalid && t < 20) begin
         tick();
         t++;
      end
      chk("arvalid_seen", m_arvalid, 1'b1);
      chk("araddr", m_araddr, exp_addr);
      for (int d = 0; d < delay; d++) begin
         tick();
         chk("arvalid_hold", m_arvalid, 1'b1);
         chk("araddr_hold", m_araddr, exp_addr);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   task automatic beats(input logic [255:0] w, input int from, input int to, input int gap);
      logic [255:0] wv;
      wv = w;
      for (int k = from; k <= to; k++) begin
         repeat (gap) tick();
         rvalid = 1'b1;
         rdata  = wv[k*32 +: 32];
         rlast  = (k == 7);
         tick();
         rvalid = 1'b0;
         rlast  = 1'b0;
      end
   endtask

   task automatic wait_refill();
      int t = 0;
      while (!m_refill_valid && t < 50) begin
         tick();
         t++;
      end
      chk("refill_seen", m_refill_valid, 1'b1);
   endtask

   task automatic end_miss();
      tick();
      miss_req = 1'b0;
      tick();
   endtask

   function automatic logic [255:0] mkline(input logic [31:0] base, input logic [31:0] step);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + step * k;
      return l;
   endfunction

   logic [255:0] w1, p2, p3, w4, w5, w6, w7, w8;
   int a0;

   initial begin
      w1 = mkline(32'h11, 32'h11);
      p2 = mkline(32'hA0000000, 32'h01010101);
      p3 = mkline(32'hC0DE0000, 32'h00000100);
      w4 = mkline(32'h40400000, 32'h3);
      w5 = mkline(32'h55550000, 32'h10);
      w6 = mkline(32'h20200000, 32'h7);
      w7 = mkline(32'h30300000, 32'h9);
      w8 = mkline(32'hFFFF0000, 32'h5);

      // Reset state
      #2;
      chk("rst_refill_valid", refill_valid, 1'b0);
      chk("rst_refill_line", refill_line, '0);
      chk("rst_line_addr", line_addr, '0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_counts", {hit_cnt, miss_cnt}, '0);
      tick();
      resetn = 1'b1;
      tick();

      // Cold miss, prefetcher idle
      push(27'h10, w1, 27'h11, 1'b1);
      miss_addr = 27'h10; miss_req = 1'b1;
      ar_phase(32'h00000200, 0);
      beats(w1, 0, 7, 0);
      wait_refill();
      end_miss();
      chk("miss_count_1", miss_cnt, 32'd1);

      // Sequential miss served by a ready prefetch buffer
      a0 = ack_cnt;
      pf_addr = 27'h11; pf_ready = 1'b1; pf_inst = p2;
      push(27'h11, p2, 27'h12, 1'b1);
      miss_addr = 27'h11; miss_req = 1'b1;
      #1;
      chk("hit_pf_ack", pf_ack, 1'b1);
      tick();
      pf_ready = 1'b0;
      chk("hit_no_arvalid", arvalid, 1'b0);
      wait_refill();
      end_miss();
      chk("hit_count_1", hit_cnt, 32'd1);
      chk("hit_ack_once", ack_cnt - a0, 1);

      // Miss on the line being prefetched: wait for it
      pf_addr = 27'h12; pf_fetching = 1'b1; pf_inst = p3;
      push(27'h12, p3, 27'h13, 1'b1);
      miss_addr = 27'h12; miss_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_no_ack", pf_ack, 1'b0);
         chk("wait_no_arvalid", arvalid, 1'b0);
      end
      pf_ready = 1'b1; pf_fetching = 1'b0;
      #1;
      chk("wait_pf_ack", pf_ack, 1'b1);
      tick();
      pf_ready = 1'b0;
      wait_refill();
      end_miss();
      chk("hit_count_2", hit_cnt, 32'd2);

      // Prefetcher busy on another line: own AXI burst, no ack
      a0 = ack_cnt;
      pf_addr = 27'h13; pf_fetching = 1'b1;
      push(27'h40, w4, 27'h41, 1'b0);
      miss_addr = 27'h40; miss_req = 1'b1;
      ar_phase(32'h00000800, 0);
      beats(w4, 0, 7, 0);
      wait_refill();
      end_miss();
      chk("other_line_no_ack", ack_cnt - a0, 0);
      pf_fetching = 1'b0;

      // Slow arready and gapped read data
      push(27'h55, w5, 27'h56, 1'b1);
      miss_addr = 27'h55; miss_req = 1'b1;
      ar_phase(32'h00000AA0, 4);
      beats(w5, 0, 7, 2);
      wait_refill();
      end_miss();
      chk("miss_count_3", miss_cnt, 32'd3);

      // Reset in the middle of a burst
      miss_addr = 27'h20; miss_req = 1'b1;
      ar_phase(32'h00000400, 0);
      beats(w6, 0, 2, 0);
      resetn = 1'b0;
      #1;
      chk("midrst_rready", rready, 1'b0);
      chk("midrst_line", refill_line, '0);
      chk("midrst_line_addr", line_addr, '0);
      chk("midrst_outs", {refill_valid, need_pf, pf_ack, arvalid}, '0);
      chk("midrst_araddr", araddr, '0);
      chk("midrst_counts", {hit_cnt, miss_cnt}, '0);
      tick();
      tick();
      resetn = 1'b1;
      push(27'h20, w6, 27'h21, 1'b1);
      ar_phase(32'h00000400, 0);
      beats(w6, 0, 7, 0);
      wait_refill();
      end_miss();
      chk("post_rst_counts", {hit_cnt, miss_cnt}, {32'd0, 32'd1});

      // Top line: next-line hint wraps to 0
      push(27'h7FFFFFF, w8, 27'h0, 1'b1);
      miss_addr = 27'h7FFFFFF; miss_req = 1'b1;
      ar_phase(32'hFFFFFFE0, 0);
      beats(w8, 0, 7, 0);
      wait_refill();
      end_miss();
      chk("wrap_line_addr", line_addr, 27'h0);

      // Prefetch disabled: matching ready buffer is ignored
      resetn = 1'b0;
      resetn0 = 1'b1;
      sel0 = 1'b1;
      tick();
      pf_addr = 27'h30; pf_ready = 1'b1; pf_inst = p2;
      miss_addr = 27'h30; miss_req = 1'b1;
      #1;
      chk("nopf_no_ack", z_pf_ack, 1'b0);
      ar_phase(32'h00000600, 0);
      pf_ready = 1'b0;
      beats(w7, 0, 7, 0);
      wait_refill();
      chk("nopf_line", z_refill_line, w7);
      chk("nopf_addr", z_refill_addr, 27'h30);
      chk("nopf_need_pf", z_need_pf, 1'b0);
      end_miss();
      chk("nopf_ack_total", z_ack_cnt, 0);
      chk("nopf_counts", {z_hit_cnt, z_miss_cnt}, {32'd0, 32'd1});

      chk("sb_empty", sb.size(), 0);
      chk("refill_pulses", refills, pushed);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Instruction-cache miss handler. Sits between the icache miss path and the line prefetcher, and consumes the prefetcher's buffered line.
- On a miss it takes the line from the prefetch buffer when the buffer holds (or is fetching) that line; otherwise it runs its own 8-beat AXI burst.
- After every refill it asks the prefetcher to fetch the next sequential line.

Parameters:
- LINE_ADDR_W, 27, line address width (32-bit byte address minus 5 offset bits).
- PF_ENABLE, 1, when 0 the block never asserts need_prefetch_o and never uses the prefetch buffer.

Ports:
- clock  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
- miss_req_i  in  1  level. Held by the cache until refill_valid_o.
- miss_line_addr_i  in  LINE_ADDR_W  missing line address, stable while miss_req_i=1.
- refill_valid_o  out  1  one-cycle pulse: refill_line_o and refill_addr_o are valid.
- refill_addr_o  out  LINE_ADDR_W  line being returned.
- refill_line_o  out  256  word k in bits [32k+31:32k], held until the next refill.
- line_addr_o  out  LINE_ADDR_W  current-line hint to the prefetcher (cur_line register).
- need_prefetch_o  out  1  prefetch request.
- pf_ack_o  out  1  consume the prefetch buffer.
- pf_addr_i  in  LINE_ADDR_W  line held or being fetched by the prefetcher.
- pf_ready_i  in  1  prefetch buffer is full.
- pf_fetching_i  in  1  prefetcher is busy.
- pf_inst_i  in  256  prefetched words 0..7, same packing as refill_line_o.
- axi_araddr_o  out  32  read address.
- axi_arvalid_o  out  1  read address valid.
- axi_arready_i  in  1  read address ready.
- axi_rdata_i  in  32  read data.
- axi_rvalid_i  in  1  read data valid.
- axi_rlast_i  in  1  last beat of the burst.
- axi_rready_o  out  1  read data ready.
- hit_count_o  out  32  refills served from the prefetch buffer.
- miss_count_o  out  32  refills served by AXI.

Behaviour:
- Reset (asynchronous, resetn=0). All outputs are 0:
  - state=IDLE, cur_line=0, beat_cnt=0, refill_line_o=0, counters=0.
  - An in-flight AXI burst is abandoned. The interconnect is reset by the same resetn.
- Definitions:
  - hit = PF_ENABLE & pf_ready_i & (pf_addr_i==miss_line_addr_i).
  - pend = PF_ENABLE & pf_fetching_i & (pf_addr_i==miss_line_addr_i).
- Default outputs: all handshake outputs are 0 except where stated. line_addr_o=cur_line always.
- IDLE:
  - On miss_req_i: cur_line<=miss_line_addr_i.
  - If hit: pf_ack_o=1 in the same cycle, capture pf_inst_i into refill_line_o, hit_count+1, go to DONE. Prefetch-hit latency is 1 cycle: refill_valid_o is asserted in the next cycle.
  - Else if pend: go to WAIT_PF.
  - Else: go to ADDR.
- WAIT_PF:
  - If pf_ready_i & pf_addr_i==miss_line_addr_i: pf_ack_o=1, capture, hit_count+1, go to DONE.
  - Else if !pf_fetching_i & !pf_ready_i (prefetcher dropped the line): go to ADDR.
  - Else stay.
- ADDR:
  - axi_arvalid_o=1, axi_araddr_o={miss_line_addr_i,5'b0}. Hold both until axi_arready_i.
  - On handshake: beat_cnt<=0, go to READ.
- READ:
  - axi_rready_o=1.
  - Each beat with rvalid: write word beat_cnt of refill_line_o, beat_cnt+1 (3-bit, wraps 7 to 0).
  - Beat with rlast & beat_cnt==7: miss_count+1, go to DONE.
  - rlast on any other beat: store the word and stay in READ. This is an interconnect protocol violation and is not flagged.
- DONE:
  - refill_valid_o=1 for exactly one cycle. refill_addr_o = latched miss line.
  - cur_line<=miss line+1 (modulo 2^LINE_ADDR_W, wraps to 0).
  - need_prefetch_o = PF_ENABLE & !pf_fetching_i & !pf_ready_i.
  - Go to IDLE unconditionally.
  - The cache must drop miss_req_i in the cycle after refill_valid_o. A new miss is accepted no earlier than the cycle after DONE.
- need_prefetch_o is asserted only in DONE, at which point line_addr_o already equals the next line.
- pf_ack_o is never asserted in ADDR or READ.
- A prefetcher busy on a different line does not block the miss: the block proceeds to its own AXI port.
- Counters wrap at 2^32.

Test Plan:
- Cold miss, line 0x0000010, prefetcher idle -> ADDR with araddr 0x00000200. Beats 0x11..0x88 land in words 0..7. refill_valid_o 1 cycle. need_prefetch_o=1 with line_addr_o=0x0000011. miss_count=1.
- Sequential miss to 0x0000011 with pf_ready_i=1, pf_addr_i=0x0000011 -> pf_ack_o in the miss cycle. refill_valid_o the next cycle, refill_line_o=pf_inst_i. No arvalid. hit_count=1.
- Miss to 0x0000012 while pf_fetching_i=1, pf_addr_i=0x0000012; pf_ready_i rises 5 cycles later -> stays in WAIT_PF with no arvalid, then acks and refills.
- Miss to 0x0000040 while the prefetcher fetches 0x0000013 -> immediate own AXI burst. No pf_ack_o.
- axi_arready_i low for 4 cycles, rvalid gaps between beats -> araddr/arvalid stable. Words in the correct slots. refill_valid_o exactly once.
- resetn low mid-READ after 3 beats -> all outputs 0 immediately. Miss after release restarts with a fresh ADDR. Also: PF_ENABLE=0 with a matching pf_ready_i -> AXI fetch, no pf_ack_o/need_prefetch_o. Miss to line 0x7FFFFFF -> line_addr_o wraps to 0.
